// File: rtl/firin_denetleyici_pkg.sv
// Shared types and defaults for the oven controller: FSM states, thickness codes,
// default bake lengths and counter widths.
package firin_pkg;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    PISIR = 2'd1,
    SOGUT = 2'd2
  } durum_e;

  typedef enum logic [1:0] {
    INCE     = 2'd0,
    ORTA     = 2'd1,
    KALIN    = 2'd2,
    GECERSIZ = 2'd3
  } kalinlik_e;

  localparam int VARSAYILAN_SURE_INCE  = 4;
  localparam int VARSAYILAN_SURE_ORTA  = 6;
  localparam int VARSAYILAN_SURE_KALIN = 8;

  localparam int SAYI_W  = 7;
  localparam int SAYAC_W = 8;
  localparam logic [SAYI_W-1:0] SAYI_MAX = '1;

endpackage

// File: rtl/firin_denetleyici_if.sv
// Requester-side bus of the oven controller: order requests and thickness in,
// grant/reject/bake status out.
interface firin_denetleyici_if;
  import firin_pkg::*;

  logic [1:0]        istek;
  logic [1:0]        kalinlik_0;
  logic [1:0]        kalinlik_1;
  logic [1:0]        kabul;
  logic              red;
  logic              firin_calis;
  logic              aktif_istekci;
  logic              hazir;
  logic [SAYI_W-1:0] tamamlanan_sayisi;

  modport master (
    output istek, kalinlik_0, kalinlik_1,
    input  kabul, red, firin_calis, aktif_istekci, hazir, tamamlanan_sayisi
  );

  modport slave (
    input  istek, kalinlik_0, kalinlik_1,
    output kabul, red, firin_calis, aktif_istekci, hazir, tamamlanan_sayisi
  );

endinterface

// File: rtl/firin_denetleyici_rr_hakem.sv
// Two-requester round-robin arbiter: the pointer only breaks ties; a lone
// requester always wins.
module rr_hakem (
  input  logic [1:0] istek_i,
  input  logic       isaretci_i,
  output logic [1:0] kabul_o,
  output logic       indeks_o
);

  always_comb begin
    indeks_o = 1'b0;
    case (istek_i)
      2'b10:   indeks_o = 1'b1;
      2'b11:   indeks_o = isaretci_i;
      default: indeks_o = 1'b0;
    endcase
    kabul_o = (istek_i == 2'b00) ? 2'b00 : (indeks_o ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/firin_denetleyici.sv
// Oven controller: grants one of two requesters, bakes for a thickness-dependent
// number of cycles, cools for one cycle and counts completed bakes (saturating).
module firin_denetleyici
  import firin_pkg::*;
#(
  parameter int SURE_INCE  = VARSAYILAN_SURE_INCE,
  parameter int SURE_ORTA  = VARSAYILAN_SURE_ORTA,
  parameter int SURE_KALIN = VARSAYILAN_SURE_KALIN
) (
  input logic              saat,
  input logic              reset,
  firin_denetleyici_if.slave bus
);

  durum_e            durum_q, durum_d;
  logic [SAYAC_W-1:0] sayac_q, sayac_d;
  logic              isaretci_q, isaretci_d;
  logic [1:0]        kabul_q, kabul_d;
  logic              red_q, red_d;
  logic              hazir_q, hazir_d;
  logic              calis_q, calis_d;
  logic              aktif_q, aktif_d;
  logic [SAYI_W-1:0] sayi_q, sayi_d;

  logic [1:0]        hakem_kabul;
  logic              hakem_indeks;
  logic              istek_var;
  kalinlik_e         secilen;

  function automatic logic [SAYI_W-1:0] sat_artir(input logic [SAYI_W-1:0] x);
    return (x == SAYI_MAX) ? x : x + 1'b1;
  endfunction

  // Counter is loaded with length-1 so that the bake spans exactly SURE cycles.
  function automatic logic [SAYAC_W-1:0] pisirme_yukle(input kalinlik_e k);
    logic [SAYAC_W-1:0] y;
    case (k)
      INCE:    y = SAYAC_W'(SURE_INCE - 1);
      ORTA:    y = SAYAC_W'(SURE_ORTA - 1);
      default: y = SAYAC_W'(SURE_KALIN - 1);
    endcase
    return y;
  endfunction

  rr_hakem u_hakem (
    .istek_i   (bus.istek),
    .isaretci_i(isaretci_q),
    .kabul_o   (hakem_kabul),
    .indeks_o  (hakem_indeks)
  );

  assign istek_var = |bus.istek;
  assign secilen   = kalinlik_e'(hakem_indeks ? bus.kalinlik_1 : bus.kalinlik_0);

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      durum_q    <= BOS;
      sayac_q    <= '0;
      isaretci_q <= 1'b0;
      kabul_q    <= 2'b00;
      red_q      <= 1'b0;
      hazir_q    <= 1'b0;
      calis_q    <= 1'b0;
      aktif_q    <= 1'b0;
      sayi_q     <= '0;
    end else begin
      durum_q    <= durum_d;
      sayac_q    <= sayac_d;
      isaretci_q <= isaretci_d;
      kabul_q    <= kabul_d;
      red_q      <= red_d;
      hazir_q    <= hazir_d;
      calis_q    <= calis_d;
      aktif_q    <= aktif_d;
      sayi_q     <= sayi_d;
    end
  end

  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOS:     if (istek_var) durum_d = (secilen == GECERSIZ) ? SOGUT : PISIR;
      PISIR:   if (sayac_q == '0) durum_d = SOGUT;
      SOGUT:   durum_d = BOS;
      default: durum_d = BOS;
    endcase
  end

  // Requests are only looked at in BOS; PISIR and SOGUT ignore istek entirely.
  always_comb begin
    sayac_d    = sayac_q;
    isaretci_d = isaretci_q;
    kabul_d    = 2'b00;
    red_d      = 1'b0;
    hazir_d    = 1'b0;
    calis_d    = calis_q;
    aktif_d    = aktif_q;
    sayi_d     = sayi_q;
    case (durum_q)
      BOS: begin
        if (istek_var) begin
          kabul_d    = hakem_kabul;
          aktif_d    = hakem_indeks;
          isaretci_d = ~hakem_indeks;
          if (secilen == GECERSIZ) begin
            red_d = 1'b1;
          end else begin
            calis_d = 1'b1;
            sayac_d = pisirme_yukle(secilen);
          end
        end
      end
      PISIR: begin
        if (sayac_q == '0) begin
          hazir_d = 1'b1;
          calis_d = 1'b0;
          sayi_d  = sat_artir(sayi_q);
        end else begin
          sayac_d = sayac_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.kabul             = kabul_q;
  assign bus.red               = red_q;
  assign bus.hazir             = hazir_q;
  assign bus.firin_calis       = calis_q;
  assign bus.aktif_istekci     = aktif_q;
  assign bus.tamamlanan_sayisi = sayi_q;

endmodule

// File: tb/tb_firin_denetleyici.sv
// Scoreboard bench for firin_denetleyici: expected grants are queued as orders are
// driven and retired when the controller answers; bake timing and count are modelled.
module tb_firin_denetleyici;

  typedef struct {
    logic [1:0] kabul;
    logic       red;
    logic       aktif;
    int         len;
  } exp_t;

  logic saat;
  logic reset;

  firin_denetleyici_if bus();

  firin_denetleyici dut (
    .saat (saat),
    .reset(reset),
    .bus  (bus)
  );

  initial saat = 1'b0;
  always #5 saat = ~saat;

  int   checks;
  int   errors;
  int   cyc;
  exp_t sb[$];
  int   gcyc[$];
  bit   pend;
  int   g_cyc;
  int   b_len;
  int   exp_cnt;

  function automatic int bake_len(input logic [1:0] k);
    if (k == 2'd0) return 4;
    if (k == 2'd1) return 6;
    return 8;
  endfunction

  task automatic check_cycle();
    exp_t e;
    checks++;
    if (bus.kabul !== 2'b00) begin
      gcyc.push_back(cyc);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL kabul_unexpected cyc=%0d got=%b want=00", cyc, bus.kabul);
      end else begin
        e = sb.pop_front();
        if (bus.kabul !== e.kabul || bus.red !== e.red || bus.aktif_istekci !== e.aktif) begin
          errors++;
          $display("FAIL grant cyc=%0d got kabul=%b red=%b aktif=%b want kabul=%b red=%b aktif=%b",
                   cyc, bus.kabul, bus.red, bus.aktif_istekci, e.kabul, e.red, e.aktif);
        end
        if (!e.red) begin
          pend  = 1'b1;
          g_cyc = cyc;
          b_len = e.len;
        end
      end
    end else if (bus.red !== 1'b0) begin
      errors++;
      $display("FAIL red_alone cyc=%0d got=%b want=0", cyc, bus.red);
    end

    checks++;
    if (bus.hazir === 1'b1) begin
      if (!pend) begin
        errors++;
        $display("FAIL hazir_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        if (cyc - g_cyc != b_len) begin
          errors++;
          $display("FAIL hazir_latency got=%0d want=%0d", cyc - g_cyc, b_len);
        end
        pend = 1'b0;
        if (exp_cnt < 127) exp_cnt++;
      end
    end else if (bus.hazir !== 1'b0) begin
      errors++;
      $display("FAIL hazir_x cyc=%0d got=%b want=0", cyc, bus.hazir);
    end else if (pend && (cyc - g_cyc >= b_len)) begin
      errors++;
      $display("FAIL hazir_missing cyc=%0d got=0 want=1", cyc);
      pend = 1'b0;
    end

    checks++;
    if (bus.firin_calis !== pend) begin
      errors++;
      $display("FAIL firin_calis cyc=%0d got=%b want=%b", cyc, bus.firin_calis, pend);
    end

    checks++;
    if (bus.tamamlanan_sayisi !== 7'(exp_cnt)) begin
      errors++;
      $display("FAIL sayi cyc=%0d got=%0d want=%0d", cyc, bus.tamamlanan_sayisi, exp_cnt);
    end
  endtask

  task automatic step();
    @(posedge saat);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic wait_grants(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_grant_timeout got=%0d pending want=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || pend) && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0 || pend) begin
      errors++;
      $display("FAIL drain_timeout got sb=%0d pend=%b want empty", sb.size(), pend);
      sb.delete();
      pend = 1'b0;
    end
    step();
    step();
  endtask

  task automatic order(input int idx, input logic [1:0] k);
    exp_t e;
    e.kabul = (idx == 1) ? 2'b10 : 2'b01;
    e.red   = (k == 2'd3);
    e.aktif = idx[0];
    e.len   = bake_len(k);
    sb.push_back(e);
    if (idx == 1) begin
      bus.kalinlik_1 = k;
      bus.istek      = 2'b10;
    end else begin
      bus.kalinlik_0 = k;
      bus.istek      = 2'b01;
    end
    wait_grants("order");
    bus.istek = 2'b00;
  endtask

  task automatic do_reset();
    #1;
    bus.istek = 2'b00;
    reset     = 1'b1;
    #1;
    checks++;
    if ({bus.kabul, bus.red, bus.hazir, bus.firin_calis, bus.aktif_istekci,
         bus.tamamlanan_sayisi} !== 13'd0) begin
      errors++;
      $display("FAIL reset_async got kabul=%b red=%b hazir=%b calis=%b aktif=%b sayi=%0d want all 0",
               bus.kabul, bus.red, bus.hazir, bus.firin_calis, bus.aktif_istekci,
               bus.tamamlanan_sayisi);
    end
    sb.delete();
    pend    = 1'b0;
    exp_cnt = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    step();
  endtask

  task automatic test_single_order();
    order(0, 2'd0);
    drain();
    checks++;
    if (bus.tamamlanan_sayisi !== 7'd1) begin
      errors++;
      $display("FAIL single_count got=%0d want=1", bus.tamamlanan_sayisi);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    gcyc.delete();
    for (int i = 0; i < 4; i++) begin
      e.kabul = (i % 2 == 0) ? 2'b01 : 2'b10;
      e.red   = 1'b0;
      e.aktif = (i % 2 == 1);
      e.len   = 8;
      sb.push_back(e);
    end
    bus.kalinlik_0 = 2'd2;
    bus.kalinlik_1 = 2'd2;
    bus.istek      = 2'b11;
    wait_grants("b2b");
    bus.istek = 2'b00;
    drain();
    checks++;
    if (gcyc.size() != 4) begin
      errors++;
      $display("FAIL b2b_grants got=%0d want=4", gcyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (gcyc[i] - gcyc[i-1] != 10) begin
          errors++;
          $display("FAIL b2b_spacing got=%0d want=10", gcyc[i] - gcyc[i-1]);
        end
      end
    end
    checks++;
    if (bus.tamamlanan_sayisi !== 7'd4) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=4", bus.tamamlanan_sayisi);
    end
  endtask

  task automatic test_reject();
    exp_t e;
    order(0, 2'd0);
    drain();
    gcyc.delete();
    e.kabul = 2'b10;
    e.red   = 1'b1;
    e.aktif = 1'b1;
    e.len   = 0;
    sb.push_back(e);
    bus.kalinlik_1 = 2'd3;
    bus.istek      = 2'b10;
    wait_grants("reject");
    e.kabul = 2'b01;
    e.red   = 1'b0;
    e.aktif = 1'b0;
    e.len   = 4;
    sb.push_back(e);
    bus.kalinlik_0 = 2'd0;
    bus.kalinlik_1 = 2'd0;
    bus.istek      = 2'b11;
    wait_grants("after_reject");
    bus.istek = 2'b00;
    drain();
    checks++;
    if (gcyc.size() != 2) begin
      errors++;
      $display("FAIL reject_grants got=%0d want=2", gcyc.size());
    end else if (gcyc[1] - gcyc[0] != 2) begin
      errors++;
      $display("FAIL reject_gap got=%0d want=2", gcyc[1] - gcyc[0]);
    end
  endtask

  task automatic test_reset_mid_bake();
    order(0, 2'd2);
    step();
    step();
    do_reset();
    for (int i = 0; i < 12; i++) step();
    order(0, 2'd0);
    drain();
    checks++;
    if (bus.tamamlanan_sayisi !== 7'd1) begin
      errors++;
      $display("FAIL reset_then_count got=%0d want=1", bus.tamamlanan_sayisi);
    end
  endtask

  task automatic test_thickness_change();
    order(0, 2'd0);
    bus.kalinlik_0 = 2'd2;
    drain();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 130; i++) begin
      order(i % 2, 2'd0);
      drain();
    end
    checks++;
    if (bus.tamamlanan_sayisi !== 7'd127) begin
      errors++;
      $display("FAIL saturation got=%0d want=127", bus.tamamlanan_sayisi);
    end
    order(1, 2'd1);
    drain();
    checks++;
    if (bus.tamamlanan_sayisi !== 7'd127) begin
      errors++;
      $display("FAIL saturation_hold got=%0d want=127", bus.tamamlanan_sayisi);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    cyc            = 0;
    pend           = 1'b0;
    g_cyc          = 0;
    b_len          = 0;
    exp_cnt        = 0;
    reset          = 1'b0;
    bus.istek      = 2'b00;
    bus.kalinlik_0 = 2'd0;
    bus.kalinlik_1 = 2'd0;

    test_reset();
    test_single_order();
    test_back_to_back();
    test_reject();
    test_reset_mid_bake();
    test_thickness_change();
    test_saturation();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/firin_denetleyici.md
FIRIN_DENETLEYICI -- requirements
Module: firin_denetleyici

Interface
REQ-001 Ports SHALL be, clock and reset first:
- saat  in  1  system clock; all state updates on rising edge.
- reset  in  1  reset; one clock, reset is asynchronous and active-high.
- istek  in  2  order request; bit i from requester i (0 salon, 1 paket).
- kalinlik_0  in  2  requester 0 thickness (0 ince, 1 orta, 2 kalin, 3 invalid).
- kalinlik_1  in  2  requester 1 thickness, same coding.
- kabul  out  2  one-cycle grant pulse, one-hot or zero.
- red  out  1  one-cycle pulse; granted order rejected for thickness 3.
- firin_calis  out  1  high while the oven bakes.
- aktif_istekci  out  1  index of the last granted requester.
- hazir  out  1  one-cycle pulse; bake complete.
- tamamlanan_sayisi  out  7  completed-bake count.
REQ-002 Parameters SHALL be SURE_INCE = 4, SURE_ORTA = 6, SURE_KALIN = 8: bake length in cycles.

Function
REQ-003 The FSM SHALL have three states: BOS (idle), PISIR (bake) and SOGUT (cool, exactly one cycle).
REQ-004 In BOS, a rising edge with any istek bit high SHALL grant one requester.
- Registered on that edge: kabul[i] = 1, aktif_istekci = i, kalinlik_i captured.
REQ-005 Arbitration SHALL be round-robin.
- Pointer names the preferred requester; reset value 0.
- If only one requests, it wins.
- After every grant, including rejects, the pointer moves to the other requester.
REQ-006 Valid thickness grant: state SHALL go to PISIR, counter loaded with SURE-1, firin_calis = 1.
REQ-007 In PISIR, the counter SHALL decrement each edge.
- On the edge where counter == 0: hazir = 1, firin_calis = 0, count increments, state goes to SOGUT.
- Result: PISIR lasts exactly SURE cycles; hazir rises SURE cycles after kabul rises.
REQ-008 Thickness 3 grant: red = 1 with kabul; state SHALL go directly to SOGUT; no bake, no hazir, count unchanged.
REQ-009 SOGUT SHALL return to BOS on the next edge; istek is ignored in PISIR and SOGUT.
- Back-to-back valid orders therefore start every SURE+2 cycles.
REQ-010 A requester SHALL hold istek and kalinlik stable until kabul, then deassert istek within one cycle.
- Thickness changes after the grant edge SHALL NOT affect the bake in progress.
REQ-011 tamamlanan_sayisi SHALL saturate at 127 and never wrap.
REQ-012 kabul, red and hazir SHALL each be high for exactly one cycle per event and SHALL be low otherwise.

Reset
REQ-013 reset high SHALL force, immediately and without waiting for a clock edge:
- state BOS, counter 0, pointer 0;
- kabul 0, red 0, hazir 0, firin_calis 0, aktif_istekci 0, tamamlanan_sayisi 0.
REQ-014 Reset mid-bake SHALL abort the bake: no hazir, no count increment.
REQ-015 Reset SHALL take priority over every simultaneous event.
REQ-016 The first grant edge after reset release SHALL follow REQ-004 with pointer = 0.

Structure
REQ-017 A shared package firin_pkg SHALL hold:
- state encodings BOS/PISIR/SOGUT;
- thickness codes INCE/ORTA/KALIN/GECERSIZ;
- default SURE_* values;
- the count width (7).
REQ-018 Arbitration SHALL be one sub-module, rr_hakem.
- Inputs: 2-bit request, pointer.
- Outputs: one-hot grant, granted index.
- Pointer update SHALL remain in firin_denetleyici.

Verification
REQ-019 Single order: istek = 01, kalinlik_0 = 0 -> kabul = 01 one cycle; firin_calis high 4 cycles; hazir pulse 4 cycles after kabul; count = 1.
REQ-020 Both requesting continuously, both kalinlik = 2 -> kabul 01, 10, 01, 10 every 10 cycles; count = 4 after 4 bakes.
REQ-021 Reject: istek = 10, kalinlik_1 = 3 -> kabul = 10 with red = 1; no hazir, count unchanged; next grant 2 cycles later; pointer points to requester 0.
REQ-022 Reset at cycle 3 of a kalin bake -> all outputs 0 at once; no hazir; a subsequent ince order completes normally with count = 1.
REQ-023 Saturation: 130 consecutive valid ince orders -> tamamlanan_sayisi = 127, unchanged thereafter.
REQ-024 Change kalinlik_0 from 0 to 2 one cycle after kabul -> bake still lasts 4 cycles.
